// File: rtl/tex_dcache_pkg.sv
// Shared types and constants for the texture dcache responder.
// The structs are sized for the default lane count and tag width.
package tex_dcache_pkg;

   localparam int DCR_NUM_REQS   = 4;
   localparam int DCR_TAG_WIDTH  = 16;
   localparam int DCR_WORD_DEPTH = 1024;
   localparam int DCR_LATENCY    = 2;
   localparam int DCR_RSPQ_SIZE  = 4;
   localparam int ADDR_WIDTH     = 30;
   localparam int WORD_WIDTH     = 32;

   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int WORD_IDX_W = idx_width(DCR_WORD_DEPTH);

   typedef struct packed {
      logic                     rw;
      logic [3:0]               byteen;
      logic [ADDR_WIDTH-1:0]    addr;
      logic [WORD_WIDTH-1:0]    data;
      logic [DCR_TAG_WIDTH-1:0] tag;
   } lane_req_t;

   typedef struct packed {
      logic [DCR_NUM_REQS-1:0]                 tmask;
      logic [DCR_NUM_REQS-1:0][WORD_WIDTH-1:0] data;
      logic [DCR_TAG_WIDTH-1:0]                tag;
   } dcache_rsp_t;

endpackage

// File: rtl/tex_dcache_responder_if.sv
// Per-lane dcache request/response bus between the texture unit and its memory side.
interface tex_dcache_responder_if #(
   parameter int NUM_REQS  = 4,
   parameter int TAG_WIDTH = 16
);
   logic [NUM_REQS-1:0]                 req_valid;
   logic [NUM_REQS-1:0]                 req_rw;
   logic [NUM_REQS-1:0][3:0]            req_byteen;
   logic [NUM_REQS-1:0][29:0]           req_addr;
   logic [NUM_REQS-1:0][31:0]           req_data;
   logic [NUM_REQS-1:0][TAG_WIDTH-1:0]  req_tag;
   logic [NUM_REQS-1:0]                 req_ready;
   logic                                rsp_valid;
   logic [NUM_REQS-1:0]                 rsp_tmask;
   logic [NUM_REQS-1:0][31:0]           rsp_data;
   logic [TAG_WIDTH-1:0]                rsp_tag;
   logic                                rsp_ready;

   modport master (
      output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_tmask, rsp_data, rsp_tag
   );

   modport slave (
      input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_tmask, rsp_data, rsp_tag
   );
endinterface

// File: rtl/VX_fifo_queue.sv
// First-word-fall-through FIFO: the head entry is visible on data_out while not empty.
module VX_fifo_queue #(
   parameter int DATAW = 1,
   parameter int SIZE  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [DATAW-1:0] data_in,
   output logic [DATAW-1:0] data_out,
   output logic             empty,
   output logic             full
);
   localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int CNT_W = $clog2(SIZE + 1);

   logic [DATAW-1:0] store_mem [SIZE];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             push_en, pop_en;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(SIZE - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(SIZE));
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop_en)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         if (push_en && !pop_en) begin
            count_reg <= count_reg + 1'b1;
         end else if (!push_en && pop_en) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) begin
         store_mem[wr_ptr_reg] <= data_in;
      end
   end

   assign data_out = store_mem[rd_ptr_reg];

endmodule

// File: rtl/VX_shift_register.sv
// Fixed-depth shift register; the top RESETW bits of every stage are reset, the rest are not.
// Expects 1 <= RESETW < DATAW and DEPTH >= 1.
module VX_shift_register #(
   parameter int DATAW  = 2,
   parameter int RESETW = 1,
   parameter int DEPTH  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [DATAW-1:0] data_in,
   output logic [DATAW-1:0] data_out
);
   localparam int PLAINW = DATAW - RESETW;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [RESETW-1:0] rst_reg;
         logic [PLAINW-1:0] plain_reg;
         logic [DATAW-1:0]  stage_in;

         if (gi == 0) begin : g_first
            assign stage_in = data_in;
         end else begin : g_next
            assign stage_in = {g_stage[gi-1].rst_reg, g_stage[gi-1].plain_reg};
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               rst_reg <= '0;
            end else if (enable) begin
               rst_reg <= stage_in[DATAW-1 -: RESETW];
            end
         end

         always_ff @(posedge clk) begin
            if (enable) begin
               plain_reg <= stage_in[PLAINW-1:0];
            end
         end
      end
   endgenerate

   assign data_out = {g_stage[DEPTH-1].rst_reg, g_stage[DEPTH-1].plain_reg};

endmodule

// File: rtl/tex_dcache_responder.sv
// Memory-side responder for the texture unit's per-lane dcache port: serves tag-grouped
// lane batches from a local word array and returns one response beat per read batch.
module tex_dcache_responder
   import tex_dcache_pkg::*;
#(
   parameter int NUM_REQS   = DCR_NUM_REQS,
   parameter int TAG_WIDTH  = DCR_TAG_WIDTH,
   parameter int WORD_DEPTH = DCR_WORD_DEPTH,
   parameter int LATENCY    = DCR_LATENCY,
   parameter int RSPQ_SIZE  = DCR_RSPQ_SIZE
) (
   input  logic                  clk,
   input  logic                  reset,
   tex_dcache_responder_if.slave bus
);
   localparam int IDX_W     = idx_width(WORD_DEPTH);
   localparam int CNT_W     = $clog2(RSPQ_SIZE + 1);
   localparam int DATA_W    = NUM_REQS * WORD_WIDTH;
   localparam int PAYLOAD_W = NUM_REQS + DATA_W + TAG_WIDTH;

   logic [TAG_WIDTH-1:0]                 leader_tag;
   logic [NUM_REQS-1:0]                  batch_mask;
   logic [NUM_REQS-1:0]                  ready_mask;
   logic [NUM_REQS-1:0]                  read_mask;
   logic [NUM_REQS-1:0]                  write_mask;
   logic                                 has_read;
   logic                                 credit_ok;
   logic                                 batch_accept;
   logic                                 read_fire;
   logic                                 rsp_pop;
   logic                                 rsp_valid_int;
   logic [CNT_W-1:0]                     outstanding_reg, outstanding_next;
   logic [WORD_WIDTH-1:0]                word_mem [WORD_DEPTH];
   logic [NUM_REQS-1:0][IDX_W-1:0]       lane_idx;
   logic [NUM_REQS-1:0][WORD_WIDTH-1:0]  rd_word;
   logic [PAYLOAD_W:0]                   pipe_in, pipe_out;
   logic [PAYLOAD_W-1:0]                 head;
   logic                                 fifo_empty;
   logic                                 unused_fifo_full;

   // Scanning downward leaves the lowest-indexed valid lane's tag as the leader.
   always_comb begin
      leader_tag = '0;
      for (int l = NUM_REQS - 1; l >= 0; l--) begin
         if (bus.req_valid[l]) leader_tag = bus.req_tag[l];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQS; gi++) begin : g_lane
         assign batch_mask[gi] = bus.req_valid[gi] && (bus.req_tag[gi] == leader_tag);
         assign lane_idx[gi]   = bus.req_addr[gi][IDX_W-1:0];
         assign rd_word[gi]    = read_mask[gi] ? word_mem[lane_idx[gi]] : '0;
         if (IDX_W < ADDR_WIDTH) begin : g_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.req_addr[gi][ADDR_WIDTH-1:IDX_W];
         end
      end
   endgenerate

   // A pop this cycle frees a slot, so a full responder can still take a read batch.
   assign has_read     = |(batch_mask & ~bus.req_rw);
   assign rsp_pop      = rsp_valid_int && bus.rsp_ready;
   assign credit_ok    = (outstanding_reg < CNT_W'(RSPQ_SIZE)) || rsp_pop;
   assign batch_accept = reset && (|batch_mask) && (!has_read || credit_ok);
   assign ready_mask   = batch_accept ? batch_mask : '0;
   assign read_mask    = ready_mask & ~bus.req_rw;
   assign write_mask   = ready_mask & bus.req_rw;
   assign read_fire    = |read_mask;
   assign bus.req_ready = ready_mask;

   // Later loop iterations overwrite earlier ones, so the highest lane wins each byte.
   always_ff @(posedge clk) begin
      for (int l = 0; l < NUM_REQS; l++) begin
         if (write_mask[l]) begin
            for (int b = 0; b < 4; b++) begin
               if (bus.req_byteen[l][b]) begin
                  word_mem[lane_idx[l]][b*8 +: 8] <= bus.req_data[l][b*8 +: 8];
               end
            end
         end
      end
   end

   assign pipe_in = {read_fire, read_mask, rd_word, leader_tag};

   VX_shift_register #(
      .DATAW  (PAYLOAD_W + 1),
      .RESETW (1),
      .DEPTH  (LATENCY)
   ) latency_pipe (
      .clk      (clk),
      .reset    (reset),
      .enable   (1'b1),
      .data_in  (pipe_in),
      .data_out (pipe_out)
   );

   // Credits cap pipe plus queue occupancy at RSPQ_SIZE, so pushes never hit a full queue.
   VX_fifo_queue #(
      .DATAW (PAYLOAD_W),
      .SIZE  (RSPQ_SIZE)
   ) rsp_queue (
      .clk      (clk),
      .reset    (reset),
      .push     (pipe_out[PAYLOAD_W]),
      .pop      (rsp_pop),
      .data_in  (pipe_out[PAYLOAD_W-1:0]),
      .data_out (head),
      .empty    (fifo_empty),
      .full     (unused_fifo_full)
   );

   assign rsp_valid_int = !fifo_empty;
   assign bus.rsp_valid = rsp_valid_int;
   assign bus.rsp_tmask = rsp_valid_int ? head[PAYLOAD_W-1 -: NUM_REQS] : '0;
   assign bus.rsp_data  = rsp_valid_int ? head[TAG_WIDTH +: DATA_W] : '0;
   assign bus.rsp_tag   = rsp_valid_int ? head[TAG_WIDTH-1:0] : '0;

   always_comb begin
      outstanding_next = outstanding_reg;
      if (read_fire && !rsp_pop) begin
         outstanding_next = outstanding_reg + 1'b1;
      end else if (!read_fire && rsp_pop) begin
         outstanding_next = outstanding_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         outstanding_reg <= '0;
      end else begin
         outstanding_reg <= outstanding_next;
      end
   end

endmodule

// File: tb/tb_tex_dcache_responder.sv
// Directed bench for tex_dcache_responder: write/read-back, byte enables, tag split,
// backpressure with credit limit, accept-with-pop at full credit and reset mid-flight.
module tb_tex_dcache_responder;
   import tex_dcache_pkg::*;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   tex_dcache_responder_if #(.NUM_REQS(4), .TAG_WIDTH(16)) bus_if ();

   tex_dcache_responder #(
      .NUM_REQS   (4),
      .TAG_WIDTH  (16),
      .WORD_DEPTH (1024),
      .LATENCY    (2),
      .RSPQ_SIZE  (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
         $display("ok   %s: %h", tag, got);
      end
   endtask

   function automatic lane_req_t mk_req(input logic rw, input logic [3:0] be,
                                        input logic [29:0] addr, input logic [31:0] data,
                                        input logic [15:0] tag);
      lane_req_t r;
      r.rw = rw; r.byteen = be; r.addr = addr; r.data = data; r.tag = tag;
      return r;
   endfunction

   function automatic dcache_rsp_t mk_rsp(input logic [3:0] m, input logic [127:0] d,
                                          input logic [15:0] t);
      dcache_rsp_t r;
      r.tmask = m; r.data = d; r.tag = t;
      return r;
   endfunction

   task automatic clear_req();
      bus_if.req_valid  = '0;
      bus_if.req_rw     = '0;
      bus_if.req_byteen = '0;
      bus_if.req_addr   = '0;
      bus_if.req_data   = '0;
      bus_if.req_tag    = '0;
   endtask

   task automatic set_lane(input int l, input lane_req_t r);
      bus_if.req_valid[l]  = 1'b1;
      bus_if.req_rw[l]     = r.rw;
      bus_if.req_byteen[l] = r.byteen;
      bus_if.req_addr[l]   = r.addr;
      bus_if.req_data[l]   = r.data;
      bus_if.req_tag[l]    = r.tag;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for a beat, compares it, then lets it pop on the next edge.
   task automatic wait_beat(input string name, input dcache_rsp_t exp, input int budget);
      int n = 0;
      while (!bus_if.rsp_valid && n < budget) begin
         step();
         n++;
      end
      check_eq({name, "_valid"}, bus_if.rsp_valid, 1'b1);
      if (bus_if.rsp_valid) begin
         check_eq({name, "_tmask"}, bus_if.rsp_tmask, exp.tmask);
         check_eq({name, "_data"},  bus_if.rsp_data,  exp.data);
         check_eq({name, "_tag"},   bus_if.rsp_tag,   exp.tag);
         step();
      end
   endtask

   initial begin
      int  k;
      logic seen;

      reset = 1'b0;
      bus_if.rsp_ready = 1'b1;
      clear_req();
      set_lane(0, mk_req(1'b0, 4'h0, 30'h10, 32'h0, 16'h1));
      #3;
      check_eq("rst_valid", bus_if.rsp_valid, 1'b0);
      check_eq("rst_tmask", bus_if.rsp_tmask, 4'h0);
      check_eq("rst_data",  bus_if.rsp_data,  128'h0);
      check_eq("rst_tag",   bus_if.rsp_tag,   16'h0);
      check_eq("rst_ready", bus_if.req_ready, 4'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      clear_req();
      step();

      // Write/read-back with exact latency
      set_lane(0, mk_req(1'b1, 4'hF, 30'h10, 32'hDEADBEEF, 16'h0));
      #1 check_eq("wr_ready", bus_if.req_ready, 4'b0001);
      step();
      clear_req();
      for (int l = 0; l < 4; l++) set_lane(l, mk_req(1'b0, 4'h0, 30'h10, 32'h0, 16'h5));
      #1 check_eq("rd_ready", bus_if.req_ready, 4'hF);
      step();
      clear_req();
      #1 check_eq("lat_e0", bus_if.rsp_valid, 1'b0);
      step();
      check_eq("lat_e1", bus_if.rsp_valid, 1'b0);
      step();
      check_eq("lat_e2_valid", bus_if.rsp_valid, 1'b1);
      check_eq("wrrd_tmask", bus_if.rsp_tmask, 4'hF);
      check_eq("wrrd_data", bus_if.rsp_data, {4{32'hDEADBEEF}});
      check_eq("wrrd_tag", bus_if.rsp_tag, 16'h5);
      step();
      check_eq("wrrd_popped", bus_if.rsp_valid, 1'b0);

      // Byte enables
      set_lane(0, mk_req(1'b1, 4'hF, 30'h20, 32'h11223344, 16'h0));
      step();
      clear_req();
      set_lane(0, mk_req(1'b1, 4'b0101, 30'h20, 32'hAABBCCDD, 16'h0));
      step();
      clear_req();
      set_lane(0, mk_req(1'b0, 4'h0, 30'h20, 32'h0, 16'h7));
      #1 check_eq("be_ready", bus_if.req_ready, 4'b0001);
      step();
      clear_req();
      wait_beat("byteen", mk_rsp(4'b0001, {96'h0, 32'h11BB33DD}, 16'h7), 8);

      // Same-batch read sees old data; highest lane wins per byte; upper address ignored
      set_lane(0, mk_req(1'b1, 4'hF, 30'h30, 32'h01020304, 16'h0));
      step();
      clear_req();
      set_lane(0, mk_req(1'b1, 4'hF,    30'h30,  32'hFFFFFFFF, 16'h3));
      set_lane(1, mk_req(1'b1, 4'b0011, 30'h30,  32'hAAAAAAAA, 16'h3));
      set_lane(2, mk_req(1'b0, 4'h0,    30'h430, 32'h0,        16'h3));
      #1 check_eq("mix_ready", bus_if.req_ready, 4'b0111);
      step();
      clear_req();
      wait_beat("prewrite", mk_rsp(4'b0100, {32'h0, 32'h01020304, 64'h0}, 16'h3), 8);
      set_lane(3, mk_req(1'b0, 4'h0, 30'h30, 32'h0, 16'h4));
      step();
      clear_req();
      wait_beat("lanewin", mk_rsp(4'b1000, {32'hFFFFAAAA, 96'h0}, 16'h4), 8);

      // Tag split
      set_lane(0, mk_req(1'b0, 4'h0, 30'h10, 32'h0, 16'h1));
      set_lane(1, mk_req(1'b0, 4'h0, 30'h20, 32'h0, 16'h2));
      set_lane(2, mk_req(1'b0, 4'h0, 30'h10, 32'h0, 16'h1));
      set_lane(3, mk_req(1'b0, 4'h0, 30'h20, 32'h0, 16'h2));
      #1 check_eq("split_c0", bus_if.req_ready, 4'b0101);
      step();
      bus_if.req_valid = 4'b1010;
      #1 check_eq("split_c1", bus_if.req_ready, 4'b1010);
      step();
      clear_req();
      wait_beat("split_a", mk_rsp(4'b0101, {32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF}, 16'h1), 8);
      wait_beat("split_b", mk_rsp(4'b1010, {32'h11BB33DD, 32'h0, 32'h11BB33DD, 32'h0}, 16'h2), 8);

      // Backpressure: only RSPQ_SIZE read batches outstanding
      bus_if.rsp_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 6; c++) begin
         clear_req();
         set_lane(0, mk_req(1'b0, 4'h0, 30'h10, 32'h0, 16'(16'h100 + k)));
         #1 check_eq($sformatf("bp_ready%0d", c), bus_if.req_ready, (c < 4) ? 4'b0001 : 4'b0000);
         if (bus_if.req_ready[0]) k++;
         step();
      end
      check_eq("bp_accepted", 32'(k), 32'd4);
      check_eq("hold_valid", bus_if.rsp_valid, 1'b1);
      check_eq("hold_tag0", bus_if.rsp_tag, 16'h100);
      repeat (3) step();
      check_eq("hold_tag1", bus_if.rsp_tag, 16'h100);
      check_eq("hold_data", bus_if.rsp_data, {96'h0, 32'hDEADBEEF});
      check_eq("hold_ready", bus_if.req_ready, 4'b0000);

      // Accept and pop in the same cycle at full credit
      bus_if.rsp_ready = 1'b1;
      #1 check_eq("full_pop_accept", bus_if.req_ready, 4'b0001);
      step();
      bus_if.rsp_ready = 1'b0;
      clear_req();
      set_lane(0, mk_req(1'b0, 4'h0, 30'h10, 32'h0, 16'h105));
      #1 check_eq("full_cnt_held", bus_if.req_ready, 4'b0000);
      check_eq("full_head_tag", bus_if.rsp_tag, 16'h101);
      clear_req();
      bus_if.rsp_ready = 1'b1;
      for (int j = 1; j <= 4; j++) begin
         wait_beat($sformatf("drain%0d", j), mk_rsp(4'b0001, {96'h0, 32'hDEADBEEF}, 16'(16'h100 + j)), 8);
      end
      check_eq("drained", bus_if.rsp_valid, 1'b0);
      set_lane(0, mk_req(1'b0, 4'h0, 30'h10, 32'h0, 16'h105));
      #1 check_eq("resume_ready", bus_if.req_ready, 4'b0001);
      step();
      clear_req();
      wait_beat("resume", mk_rsp(4'b0001, {96'h0, 32'hDEADBEEF}, 16'h105), 8);

      // Reset mid-flight
      bus_if.rsp_ready = 1'b0;
      set_lane(0, mk_req(1'b0, 4'h0, 30'h20, 32'h0, 16'h200));
      step();
      clear_req();
      set_lane(0, mk_req(1'b0, 4'h0, 30'h30, 32'h0, 16'h201));
      step();
      clear_req();
      step();
      check_eq("mid_pre_valid", bus_if.rsp_valid, 1'b1);
      reset = 1'b0;
      set_lane(0, mk_req(1'b0, 4'h0, 30'h20, 32'h0, 16'h202));
      #1 check_eq("mid_rst_valid", bus_if.rsp_valid, 1'b0);
      check_eq("mid_rst_tag", bus_if.rsp_tag, 16'h0);
      check_eq("mid_rst_ready", bus_if.req_ready, 4'b0000);
      step();
      reset = 1'b1;
      clear_req();
      bus_if.rsp_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         seen = seen | bus_if.rsp_valid;
         step();
      end
      check_eq("mid_no_rsp", seen, 1'b0);
      set_lane(0, mk_req(1'b0, 4'h0, 30'h20, 32'h0, 16'h300));
      set_lane(1, mk_req(1'b0, 4'h0, 30'h30, 32'h0, 16'h300));
      #1 check_eq("retain_ready", bus_if.req_ready, 4'b0011);
      step();
      clear_req();
      wait_beat("retain", mk_rsp(4'b0011, {64'h0, 32'hFFFFAAAA, 32'h11BB33DD}, 16'h300), 8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tex_dcache_responder.md
Name: tex_dcache_responder

Overview:
- Memory-side responder for the texture unit's per-lane dcache request/response interface.
- Accepts per-lane read/write requests and serves them from a local word-addressed array.
- Returns one response beat per accepted read batch: lane mask, per-lane data and the batch tag.
- Used as the dcache stand-in behind the texture sampler, in unit testbenches and in cache-less configurations.

Parameters:
- NUM_REQS, 4: number of request lanes.
- TAG_WIDTH, 16: per-lane request tag width; the response carries one tag.
- WORD_DEPTH, 1024: number of 32-bit words in the local array; must be a power of 2.
- LATENCY, 2: cycles from read acceptance to response availability; must be at least 1.
- RSPQ_SIZE, 4: maximum read batches outstanding, counting the latency pipe plus the response queue.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  NUM_REQS  per-lane request valid.
- req_rw  input  NUM_REQS  per-lane 1=write, 0=read.
- req_byteen  input  NUM_REQS x 4  per-lane write byte enables.
- req_addr  input  NUM_REQS x 30  per-lane word address.
- req_data  input  NUM_REQS x 32  per-lane write data.
- req_tag  input  NUM_REQS x TAG_WIDTH  per-lane tag.
- req_ready  output  NUM_REQS  per-lane accept.
- rsp_valid  output  1  response beat valid.
- rsp_tmask  output  NUM_REQS  lanes carried by this beat.
- rsp_data  output  NUM_REQS x 32  per-lane read data; masked-off lanes are 0.
- rsp_tag  output  TAG_WIDTH  batch tag.
- rsp_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (reset=0, asynchronous):
  - Latency pipe and response queue flushed; outstanding counter = 0.
  - rsp_valid=0, req_ready=0, rsp_tmask=0, rsp_data=0, rsp_tag=0.
  - Array contents are retained, not cleared.
  - Reset asserted mid-operation drops all in-flight batches; no response is produced for them after release.
- Batch formation, each cycle:
  - Leader = lowest-indexed lane with req_valid=1.
  - Batch = valid lanes whose req_tag equals the leader's tag.
  - Other valid lanes get req_ready=0 and must hold their requests.
- Batch acceptance:
  - Write-only batch: always accepted.
  - Batch containing any read: accepted only if outstanding < RSPQ_SIZE, or a beat pops this cycle (rsp_valid && rsp_ready).
  - A non-accepted batch has req_ready=0 on every lane.
  - req_ready is a combinational function of req_valid, req_tag, req_rw and the credit state.
- Array access:
  - Index = req_addr[log2(WORD_DEPTH)-1:0]; upper address bits are ignored.
  - Writes are byte-enabled and commit at the acceptance edge. Writes return no response.
  - Reads in the same batch sample pre-write contents. Any later batch sees the written data.
  - Multiple lanes may read the same word in one cycle.
  - Multiple lanes writing the same word in one batch: the highest lane index wins, per byte.
- Read path:
  - The accepted read mask, per-lane data and leader tag enter a LATENCY-stage pipe, then the response queue (depth RSPQ_SIZE, first-word-fall-through).
  - With the queue empty, rsp_valid rises exactly LATENCY cycles after the acceptance edge.
  - rsp_tmask = read lanes of the batch. Write lanes of a mixed batch are excluded.
- Outstanding counter:
  - +1 on read-batch accept, -1 on pop. Both in the same cycle leaves it unchanged.
  - Never exceeds RSPQ_SIZE.
- Response handshake:
  - A beat pops on rsp_valid && rsp_ready.
  - While rsp_valid && !rsp_ready, rsp_tmask, rsp_data and rsp_tag are held stable.
  - Beats are returned in acceptance order.

Decomposition:
- Shared package tex_dcache_pkg:
  - Lane request struct {rw, byteen, addr, data, tag}.
  - Response struct {tmask, data, tag}.
  - Constant for the word index width, derived from WORD_DEPTH.
- Response buffer: instantiate the existing VX_fifo_queue, SIZE=RSPQ_SIZE.
- Latency pipe: existing VX_shift_register, with the valid bit reset.
- The array and batch selector stay inline.

Test Plan:
- Write/read-back:
  - Stimulus: lane0 write addr 0x10, data 0xDEADBEEF, byteen 4'hF; next cycle lanes0-3 read addr 0x10, tag 0x5.
  - Required: after LATENCY=2 cycles, rsp_tmask=4'hF, every lane 0xDEADBEEF, rsp_tag=0x5.
- Byte enables:
  - Stimulus: with word 0x20 = 0x11223344, write 0xAABBCCDD with byteen 4'b0101, then read.
  - Required: read returns 0x11BB33DD.
- Tag split:
  - Stimulus: lanes0,2 read with tag 1; lanes1,3 read with tag 2, held valid.
  - Required: cycle 0 req_ready=4'b0101; cycle 1 req_ready=4'b1010.
  - Required: beats in order {tmask 0101, tag 1}, then {tmask 1010, tag 2}.
- Backpressure:
  - Stimulus: rsp_ready=0; issue 6 read batches.
  - Required: exactly 4 accepted, then req_ready=0.
  - Required: the head beat is held stable; after rsp_ready=1, 4 beats drain in order, then acceptance resumes.
- Simultaneous accept and pop at full credit:
  - Required: the batch is accepted, the counter stays at 4, no beat is lost.
- Reset mid-flight:
  - Stimulus: accept 2 read batches, then pulse reset=0 for one cycle.
  - Required: rsp_valid=0 immediately and stays 0 afterwards.
  - Required: previously written data is still readable after reset.
